// File: rtl/opsum_readback_checker.sv
// Opsum read-back checker: walks a multi-channel opsum region in the GLB,
// compares each word against a golden valid/ready stream and reports the
// mismatch count together with the first failing location.
module opsum_readback_checker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CH_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_words,
    input  logic [CH_W-1:0]   cfg_channels,
    input  logic [ADDR_W-1:0] cfg_ch_stride,
    input  logic              cfg_stop_on_err,
    output logic              glb_ren,
    output logic [ADDR_W-1:0] glb_addr,
    input  logic [DATA_W-1:0] glb_rdata,
    input  logic              gold_valid,
    output logic              gold_ready,
    input  logic [DATA_W-1:0] gold_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        CMP,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Run configuration captured on the accepted start
    logic [CNT_W-1:0]  words_q;
    logic [CH_W-1:0]   chans_q;
    logic [ADDR_W-1:0] stride_q;
    logic              stop_q;

    // Walk position and the address of word 0 of the current channel
    logic [CNT_W-1:0]  w_q;
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W-1:0] ch_addr_q;

    logic [DATA_W-1:0] data_q;

    logic cfg_empty;
    logic hs;
    logic mismatch;
    logic w_wrap;
    logic last_word;

    assign cfg_empty = (cfg_words == '0) || (cfg_channels == '0);
    assign hs        = (state == CMP) && gold_valid;
    assign mismatch  = (data_q != gold_data);
    assign w_wrap    = ((w_q + CNT_W'(1)) == words_q);
    assign last_word = w_wrap && ((ch_q + CH_W'(1)) == chans_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt  = state;
        glb_ren    = 1'b0;
        gold_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = cfg_empty ? DONE : RD;
                end
            end
            RD: begin
                glb_ren   = 1'b1;
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = CMP;
            end
            CMP: begin
                gold_ready = 1'b1;
                if (gold_valid) begin
                    state_nxt = (last_word || (mismatch && stop_q)) ? DONE : RD;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Configuration latch, address walk, read-data capture and result tracking.
    // glb_addr is only reloaded on a transition into RD so it holds the last
    // read address (used for first_err_addr) through CAP, CMP and beyond.
    always_ff @(posedge clk) begin
        if (!rst) begin
            words_q        <= '0;
            chans_q        <= '0;
            stride_q       <= '0;
            stop_q         <= 1'b0;
            w_q            <= '0;
            ch_q           <= '0;
            ch_addr_q      <= '0;
            data_q         <= '0;
            glb_addr       <= '0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        words_q        <= cfg_words;
                        chans_q        <= cfg_channels;
                        stride_q       <= cfg_ch_stride;
                        stop_q         <= cfg_stop_on_err;
                        w_q            <= '0;
                        ch_q           <= '0;
                        ch_addr_q      <= cfg_base_addr;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_got  <= '0;
                        first_err_exp  <= '0;
                        pass           <= cfg_empty;
                        if (!cfg_empty) begin
                            glb_addr <= cfg_base_addr;
                        end
                    end
                end
                CAP: begin
                    data_q <= glb_rdata;
                end
                CMP: begin
                    if (hs) begin
                        if (mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (err_count == '0) begin
                                first_err_addr <= glb_addr;
                                first_err_got  <= data_q;
                                first_err_exp  <= gold_data;
                            end
                        end
                        if (w_wrap) begin
                            w_q       <= '0;
                            ch_q      <= ch_q + CH_W'(1);
                            ch_addr_q <= ch_addr_q + stride_q;
                        end else begin
                            w_q <= w_q + CNT_W'(1);
                        end
                        if (state_nxt == RD) begin
                            glb_addr <= w_wrap ? (ch_addr_q + stride_q)
                                               : (glb_addr + WORD_BYTES);
                        end
                        if (state_nxt == DONE) begin
                            pass <= !mismatch && (err_count == '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opsum_readback_checker.sv
// Directed bench for opsum_readback_checker with a GLB/golden-stream model
// and a reference walk of the opsum region.
module tb_opsum_readback_checker;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CH_W   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [CNT_W-1:0]  cfg_words = '0;
    logic [CH_W-1:0]   cfg_channels = '0;
    logic [ADDR_W-1:0] cfg_ch_stride = '0;
    logic              cfg_stop_on_err = 1'b0;
    logic              glb_ren;
    logic [ADDR_W-1:0] glb_addr;
    logic [DATA_W-1:0] glb_rdata = '0;
    logic              gold_valid = 1'b0;
    logic              gold_ready;
    logic [DATA_W-1:0] gold_data = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [DATA_W-1:0] first_err_got;
    logic [DATA_W-1:0] first_err_exp;

    opsum_readback_checker #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W),
        .CH_W  (CH_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_words      (cfg_words),
        .cfg_channels   (cfg_channels),
        .cfg_ch_stride  (cfg_ch_stride),
        .cfg_stop_on_err(cfg_stop_on_err),
        .glb_ren        (glb_ren),
        .glb_addr       (glb_addr),
        .glb_rdata      (glb_rdata),
        .gold_valid     (gold_valid),
        .gold_ready     (gold_ready),
        .gold_data      (gold_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_got  (first_err_got),
        .first_err_exp  (first_err_exp)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    // GLB contents and golden stream for the current run
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] gold_list [$];
    bit                stall_mode = 1'b0;
    int                run_id = 0;
    int                hs_count = 0;

    // Reference results of the current run
    logic [ADDR_W-1:0] exp_addr [$];
    int                m_err;
    int                m_hs;
    logic [ADDR_W-1:0] m_first_addr;
    logic [DATA_W-1:0] m_first_got;
    logic [DATA_W-1:0] m_first_exp;
    logic              m_pass;
    bit                model_on = 1'b1;
    int                rd_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_mem(input logic [ADDR_W-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // Walk the region channel-major and derive every expected outcome
    task automatic build_model(input logic [ADDR_W-1:0] base, input int words, input int chans,
                               input logic [ADDR_W-1:0] stride, input bit stop);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] want;
        bit                halted;
        exp_addr.delete();
        m_err = 0;
        m_hs = 0;
        m_first_addr = '0;
        m_first_got = '0;
        m_first_exp = '0;
        halted = 1'b0;
        for (int c = 0; c < chans; c++) begin
            for (int w = 0; w < words; w++) begin
                if (!halted) begin
                    a = base + ADDR_W'(c) * stride + ADDR_W'(w * 4);
                    got = rd_mem(a);
                    want = gold_list[m_hs];
                    exp_addr.push_back(a);
                    m_hs++;
                    if (got != want) begin
                        m_err++;
                        if (m_err == 1) begin
                            m_first_addr = a;
                            m_first_got = got;
                            m_first_exp = want;
                        end
                        if (stop) halted = 1'b1;
                    end
                end
            end
        end
        m_pass = (m_err == 0);
    endtask

    // GLB read port (1-cycle latency) and golden stream source
    initial begin
        int  src_run = 0;
        int  gold_idx = 0;
        bit  hs_pending = 1'b0;
        bit  ren_prev = 1'b0;
        logic [ADDR_W-1:0] addr_prev = '0;
        forever begin
            @(negedge clk);
            if (src_run != run_id) begin
                src_run = run_id;
                gold_idx = 0;
                hs_pending = 1'b0;
            end else if (hs_pending) begin
                gold_idx++;
                hs_count++;
            end
            gold_valid = (gold_idx < gold_list.size()) &&
                         (!stall_mode || ($urandom_range(0, 1) == 1));
            gold_data = (gold_idx < gold_list.size()) ? gold_list[gold_idx] : '0;
            hs_pending = gold_valid && gold_ready && rst;
            glb_rdata = ren_prev ? rd_mem(addr_prev) : '0;
            ren_prev = glb_ren;
            addr_prev = glb_addr;
        end
    end

    // Per-cycle comparison of read addresses and end-of-run results
    always @(negedge clk) begin
        if (!rst) begin
            rd_idx = 0;
        end else begin
            if (glb_ren) begin
                if (!model_on)
                    check("ren_while_idle", 64'(glb_ren), 64'd0);
                else if (rd_idx >= exp_addr.size())
                    check("read_count", 64'(rd_idx + 1), 64'(exp_addr.size()));
                else
                    check("glb_addr", 64'(glb_addr), 64'(exp_addr[rd_idx]));
                rd_idx++;
            end
            if (done) begin
                check("done_expected", 64'(done), 64'(model_on));
                if (model_on) begin
                    check("final_read_count", 64'(rd_idx), 64'(exp_addr.size()));
                    check("err_count", 64'(err_count), 64'(m_err));
                    check("pass", 64'(pass), 64'(m_pass));
                    check("first_err_addr", 64'(first_err_addr), 64'(m_first_addr));
                    check("first_err_got", 64'(first_err_got), 64'(m_first_got));
                    check("first_err_exp", 64'(first_err_exp), 64'(m_first_exp));
                    if (exp_addr.size() > 0)
                        check("glb_addr_hold", 64'(glb_addr), 64'(exp_addr[exp_addr.size() - 1]));
                end
                rd_idx = 0;
            end
        end
    end

    task automatic run(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] words,
                       input logic [CH_W-1:0] chans, input logic [ADDR_W-1:0] stride,
                       input logic stop, input bit poke_start, output int lat, output int hs);
        int h0;
        int t0;
        build_model(base, int'(words), int'(chans), stride, stop);
        run_id++;
        cfg_base_addr = base;
        cfg_words = words;
        cfg_channels = chans;
        cfg_ch_stride = stride;
        cfg_stop_on_err = stop;
        @(negedge clk);
        h0 = hs_count;
        t0 = int'(cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_base_addr = ~base;
        cfg_words = words + CNT_W'(3);
        cfg_channels = chans + CH_W'(1);
        cfg_ch_stride = stride + ADDR_W'(16);
        cfg_stop_on_err = ~stop;
        lat = -1;
        for (int i = 0; i < 500; i++) begin
            if (done) begin
                lat = int'(cyc) - t0;
                break;
            end
            if (poke_start) start = (i == 2) || (i == 6);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 64'(lat >= 0), 64'd1);
        @(negedge clk);
        hs = hs_count - h0;
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
        check("handshakes", 64'(hs), 64'(m_hs));
    endtask

    task automatic load_ch3(input bit with_errors);
        mem.delete();
        gold_list = '{32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 32'hC};
        mem[16'h0200] = 32'h7;
        mem[16'h0204] = 32'h8;
        mem[16'h0240] = 32'h9;
        mem[16'h0244] = with_errors ? 32'hDEADBEEF : 32'hA;
        mem[16'h0280] = 32'hB;
        mem[16'h0284] = with_errors ? 32'h11 : 32'hC;
    endtask

    task automatic load_t1();
        mem.delete();
        gold_list = '{32'h1, 32'h2, 32'h3, 32'h4};
        mem[16'h0100] = 32'h1;
        mem[16'h0104] = 32'h2;
        mem[16'h0108] = 32'h3;
        mem[16'h010C] = 32'h4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hs;
        int h0;

        repeat (3) @(negedge clk);
        check("rst_glb_ren", 64'(glb_ren), 64'd0);
        check("rst_glb_addr", 64'(glb_addr), 64'd0);
        check("rst_gold_ready", 64'(gold_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_first_err_addr", 64'(first_err_addr), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1 channel x 4 words, all matching
        load_t1();
        run(16'h0100, 16'd4, 8'd1, 16'h0000, 1'b0, 1'b0, lat, hs);
        check("t1_model_addr3", 64'(exp_addr[3]), 64'h010C);
        check("t1_latency", 64'(lat), 64'd13);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_err", 64'(err_count), 64'd0);

        // 3 channels x 2 words, stride 0x40, all matching
        load_ch3(1'b0);
        run(16'h0200, 16'd2, 8'd3, 16'h0040, 1'b0, 1'b0, lat, hs);
        check("t2_model_addr2", 64'(exp_addr[2]), 64'h0240);
        check("t2_model_addr5", 64'(exp_addr[5]), 64'h0284);
        check("t2_handshakes", 64'(hs), 64'd6);
        check("t2_latency", 64'(lat), 64'd19);
        check("t2_pass", 64'(pass), 64'd1);

        // Two mismatches, run to completion
        load_ch3(1'b1);
        run(16'h0200, 16'd2, 8'd3, 16'h0040, 1'b0, 1'b0, lat, hs);
        check("t3_model_err", 64'(m_err), 64'd2);
        check("t3_err", 64'(err_count), 64'd2);
        check("t3_first_addr", 64'(first_err_addr), 64'h0244);
        check("t3_first_got", 64'(first_err_got), 64'hDEADBEEF);
        check("t3_first_exp", 64'(first_err_exp), 64'h0000000A);
        check("t3_pass", 64'(pass), 64'd0);
        check("t3_handshakes", 64'(hs), 64'd6);

        // Empty configurations finish immediately with pass
        run(16'h0300, 16'd0, 8'd2, 16'h0010, 1'b0, 1'b0, lat, hs);
        check("empty_words_latency", 64'(lat), 64'd1);
        check("empty_words_pass", 64'(pass), 64'd1);
        load_ch3(1'b1);
        run(16'h0200, 16'd2, 8'd3, 16'h0040, 1'b0, 1'b0, lat, hs);
        run(16'h0300, 16'd4, 8'd0, 16'h0010, 1'b0, 1'b0, lat, hs);
        check("empty_chans_latency", 64'(lat), 64'd1);
        check("empty_chans_err", 64'(err_count), 64'd0);

        // Stop on first error
        load_ch3(1'b1);
        run(16'h0200, 16'd2, 8'd3, 16'h0040, 1'b1, 1'b0, lat, hs);
        check("t4_handshakes", 64'(hs), 64'd4);
        check("t4_latency", 64'(lat), 64'd13);
        check("t4_err", 64'(err_count), 64'd1);
        check("t4_first_addr", 64'(first_err_addr), 64'h0244);
        repeat (5) @(negedge clk);
        check("t4_no_ren", 64'(glb_ren), 64'd0);

        // Address wrap with random stalls and start pulses while busy
        mem.delete();
        gold_list = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        mem[16'hFFF8] = 32'h11111111;
        mem[16'hFFFC] = 32'h22222222;
        mem[16'h0000] = 32'h33333333;
        mem[16'h0004] = 32'h44444444;
        stall_mode = 1'b1;
        run(16'hFFF8, 16'd4, 8'd1, 16'h0000, 1'b0, 1'b1, lat, hs);
        stall_mode = 1'b0;
        check("t5_model_addr2", 64'(exp_addr[2]), 64'h0000);
        check("t5_model_addr3", 64'(exp_addr[3]), 64'h0004);
        check("t5_pass", 64'(pass), 64'd1);
        check("t5_handshakes", 64'(hs), 64'd4);
        check("t5_min_latency", 64'(lat >= 13), 64'd1);
        repeat (4) @(negedge clk);
        check("t5_no_restart", 64'(busy), 64'd0);

        // Reset during CMP abandons the run
        load_ch3(1'b1);
        build_model(16'h0200, 2, 3, 16'h0040, 1'b0);
        run_id++;
        cfg_base_addr = 16'h0200;
        cfg_words = 16'd2;
        cfg_channels = 8'd3;
        cfg_ch_stride = 16'h0040;
        cfg_stop_on_err = 1'b0;
        @(negedge clk);
        h0 = hs_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((hs_count - h0) >= 4 && gold_ready) break;
            @(negedge clk);
        end
        check("t6_in_cmp", 64'(gold_ready), 64'd1);
        check("t6_err_before_rst", 64'(err_count), 64'd1);
        model_on = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ready", 64'(gold_ready), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_err", 64'(err_count), 64'd0);
        check("t6_rst_addr", 64'(glb_addr), 64'd0);
        check("t6_rst_first_got", 64'(first_err_got), 64'd0);
        check("t6_rst_first_exp", 64'(first_err_exp), 64'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_idle_after_rst", 64'(busy), 64'd0);
        model_on = 1'b1;

        // Normal run after the abandoned one
        load_t1();
        run(16'h0100, 16'd4, 8'd1, 16'h0000, 1'b0, 1'b0, lat, hs);
        check("t7_latency", 64'(lat), 64'd13);
        check("t7_pass", 64'(pass), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
